uart_out_port: RTL and testbench
================================

// Module: uart_out_port
// PURPOSE
//  Downstream consumer of the CPU output port. Captures each 16-bit word
//  presented with a one-cycle valid strobe into a small FIFO, then transmits
//  it over a UART line as two 8N1 frames: low byte first, then high byte.
//  Decouples single-cycle CPU OUT instructions from the slow serial link.
// PARAMETERS
//  CLKS_PER_BIT  868  clock cycles per UART bit (100 MHz / 115200); legal >= 1
//  DEPTH_LOG2    3    log2 of FIFO depth in 16-bit words (default depth 8)
// PORTS
//  clk       in   1   sole clock, rising edge
//  rst       in   1   reset: synchronous, active-high
//  din       in   16  word from CPU output port
//  din_valid in   1   one-cycle strobe: din is valid this cycle
//  full      out  1   FIFO holds 2**DEPTH_LOG2 words
//  overflow  out  1   sticky: a strobe arrived while full (word dropped)
//  busy      out  1   FIFO non-empty or a frame in progress
//  tx        out  1   UART serial output, idle high
// BEHAVIOUR
//  Reset (rst=1 at a clk edge):
//   - tx=1, full=0, overflow=0, busy=0.
//   - FIFO emptied, FSM -> IDLE, bit/baud counters cleared.
//   - Applies mid-frame too: tx high from the next cycle; the partial frame
//     and all queued words are discarded.
//  FIFO:
//   - Pointers DEPTH_LOG2 bits wide, wrap naturally; count DEPTH_LOG2+1 bits.
//   - Write when din_valid && !full, with full taken as the registered value
//     at the start of the cycle. A strobe while full is dropped and sets
//     overflow, even if a pop occurs in the same cycle.
//   - Write and pop in the same cycle leave the count unchanged.
//   - Order is strictly preserved.
//  FSM states: IDLE, START, DATA, STOP. hi_sel selects the byte.
//   - IDLE: tx=1. If the FIFO is non-empty, pop the head into word_q,
//     set hi_sel=0, go to START.
//   - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
//   - DATA: tx = byte[bit_idx], LSB first. byte = hi_sel ? word_q[15:8]
//     : word_q[7:0]. Each bit is held CLKS_PER_BIT cycles. After bit 7,
//     go to STOP.
//   - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if hi_sel=0, set hi_sel=1
//     and go to START (no gap). Otherwise go to IDLE.
//   - baud counter: 0..CLKS_PER_BIT-1, reset on every state/bit change;
//     width $clog2(CLKS_PER_BIT+1).
//  Latency and timing:
//   - Strobe at edge n -> FIFO non-empty after n -> pop in IDLE at n+1
//     -> tx falls at edge n+2.
//   - One word = 20*CLKS_PER_BIT cycles of line time.
//   - One IDLE cycle separates consecutive words.
//  busy = (state != IDLE) || FIFO non-empty; registered-derived, no
//  combinational path from din_valid.
// TESTING (CLKS_PER_BIT=4, DEPTH_LOG2=3 unless stated)
//  1. Hold rst 2 cycles -> tx=1, full=0, overflow=0, busy=0; no tx edges
//     for 100 cycles.
//  2. Single strobe din=16'hA55A:
//     - tx falls 2 cycles after the strobe.
//     - Line carries 0 | 0,1,0,1,1,0,1,0 | 1 | 0 | 1,0,1,0,0,1,0,1 | 1,
//       each level for 4 cycles.
//     - busy drops after 80 line cycles.
//  3. Strobes on 10 consecutive cycles, din=0..9:
//     - word 0 popped immediately; full=1 after the 9th strobe.
//     - 10th strobe (din=9) is dropped and overflow=1.
//     - UART decodes words 0..8 in order.
//  4. Assert rst during the DATA state of the high byte:
//     - tx=1 on the next cycle; busy=0, FIFO empty.
//     - A subsequent strobe of 16'h1234 transmits correctly.
//  5. With the FIFO full, strobe in the same cycle that IDLE pops:
//     - strobe dropped, overflow=1, count goes 8 -> 7.
//  6. CLKS_PER_BIT=1, strobe 16'hFF00: 20-cycle frame pair, one cycle per
//     bit, byte 0x00 then 0xFF.

Source files
------------

// File: rtl/uart_out_port.sv
// uart_out_port: buffers 16-bit words from the CPU output port in a small FIFO
// and transmits each word as two 8N1 UART frames (low byte, then high byte).
module uart_out_port #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DEPTH_LOG2   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic        full,
  output logic        overflow,
  output logic        busy,
  output logic        tx
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned BW    = $clog2(CLKS_PER_BIT + 1);
  localparam logic [BW-1:0]         BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [15:0]           r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;

  // Transmitter state
  state_t                r_state;
  logic [15:0]           r_word;
  logic                  r_hi_sel;
  logic [2:0]            r_bit_idx;
  logic [BW-1:0]         r_baud;
  logic                  r_tx;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr;
  logic                  w_pop;
  logic                  w_baud_done;
  logic [7:0]            w_byte;

  assign w_full      = (r_count == CNT_FULL);
  assign w_empty     = (r_count == '0);
  // full is the registered occupancy, so a strobe in the same cycle as a pop
  // from a full FIFO is still dropped.
  assign w_wr        = din_valid && !w_full;
  assign w_pop       = (r_state == S_IDLE) && !w_empty;
  assign w_baud_done = (r_baud == BAUD_LAST);
  assign w_byte      = r_hi_sel ? r_word[15:8] : r_word[7:0];

  assign full     = w_full;
  assign overflow = r_overflow;
  assign busy     = (r_state != S_IDLE) || !w_empty;
  assign tx       = r_tx;

  // FIFO data array: written on every accepted strobe
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= din;
    end
  end

  // FIFO pointers, occupancy count and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (din_valid && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // UART transmit FSM; tx is registered from the current state, so the line
  // lags the state by one cycle while every level still lasts CLKS_PER_BIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_word    <= '0;
      r_hi_sel  <= 1'b0;
      r_bit_idx <= '0;
      r_baud    <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE:  r_tx <= 1'b1;
        S_START: r_tx <= 1'b0;
        S_DATA:  r_tx <= w_byte[r_bit_idx];
        default: r_tx <= 1'b1;
      endcase

      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          if (w_pop) begin
            r_word   <= r_mem[r_rptr];
            r_hi_sel <= 1'b0;
            r_state  <= S_START;
          end
        end
        S_START: begin
          if (w_baud_done) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_state   <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (!r_hi_sel) begin
              r_hi_sel <= 1'b1;
              r_state  <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_out_port.sv
// Testbench for uart_out_port: scoreboard of expected words with predicted
// line start times, a UART line monitor per instance, and a per-cycle check of
// full/busy/overflow against an occupancy model of the FIFO and transmitter.
`timescale 1ns/1ps
module tb_uart_out_port;

  localparam int CPB0  = 4;
  localparam int CPB1  = 1;
  localparam int DEPTH = 8;
  localparam int MAXW  = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din0, din1;
  logic        v0, v1;
  logic        full0, ovf0, busy0, tx0;
  logic        full1, ovf1, busy1, tx1;

  always #5 clk = ~clk;

  uart_out_port #(.CLKS_PER_BIT(CPB0), .DEPTH_LOG2(3)) u0 (
    .clk(clk), .rst(rst), .din(din0), .din_valid(v0),
    .full(full0), .overflow(ovf0), .busy(busy0), .tx(tx0)
  );

  uart_out_port #(.CLKS_PER_BIT(CPB1), .DEPTH_LOG2(3)) u1 (
    .clk(clk), .rst(rst), .din(din1), .din_valid(v1),
    .full(full1), .overflow(ovf1), .busy(busy1), .tx(tx1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  bit rx_en    = 1'b0;

  typedef struct {
    logic [15:0] w;
    int          fall;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  // Reference model: edges at which each accepted word is written and popped.
  int wr_e  [2][MAXW];
  int pop_e [2][MAXW];
  int n_acc [2];
  int last_pop [2];
  int drop_e [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_assert++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int cpb_of(input int w);
    return (w == 1) ? CPB1 : CPB0;
  endfunction

  function automatic logic get_tx(input int w);
    return (w == 1) ? tx1 : tx0;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 1) ? busy1 : busy0;
  endfunction

  // Words in the FIFO after edge c.
  function automatic int occ(input int w, input int c);
    int n = 0;
    for (int i = 0; i < n_acc[w]; i++) begin
      if (wr_e[w][i] <= c) n++;
      if (pop_e[w][i] <= c) n--;
    end
    return n;
  endfunction

  // Transmitter is in a frame pair after edge c.
  function automatic bit tx_active(input int w, input int c);
    for (int i = 0; i < n_acc[w]; i++) begin
      if (pop_e[w][i] <= c && c < pop_e[w][i] + 20 * cpb_of(w)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      n_acc[w]    = 0;
      last_pop[w] = -100000;
      drop_e[w]   = 1 << 30;
    end
    sb0.delete();
    sb1.delete();
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    model_reset();
    step(n);
    rst = 1'b0;
  endtask

  // One-cycle strobe, sampled at edge cyc+1; the model decides acceptance.
  task automatic strobe(input int which, input logic [15:0] w);
    int   t;
    int   p;
    exp_t e;
    t = cyc + 1;
    if (occ(which, t - 1) == DEPTH) begin
      if (drop_e[which] > t) drop_e[which] = t;
    end else if (n_acc[which] < MAXW) begin
      p = last_pop[which] + 20 * cpb_of(which) + 1;
      if (p < t + 1) p = t + 1;
      last_pop[which] = p;
      wr_e[which][n_acc[which]]  = t;
      pop_e[which][n_acc[which]] = p;
      n_acc[which]++;
      e.w    = w;
      e.fall = p + 1;
      if (which == 0) sb0.push_back(e);
      else            sb1.push_back(e);
    end
    if (which == 0) begin din0 = w; v0 = 1'b1; end
    else            begin din1 = w; v1 = 1'b1; end
    step(1);
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic wait_idle(input int which, input int budget);
    int k = 0;
    while (k < budget && get_busy(which) !== 1'b0) begin
      step(1);
      k++;
    end
    check($sformatf("wait_idle%0d", which), get_busy(which), 1'b0);
    step(3 * cpb_of(which) + 3);
  endtask

  // Per-cycle status flags against the model.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("full0", full0, occ(0, cyc) == DEPTH);
      check("busy0", busy0, (occ(0, cyc) > 0) || tx_active(0, cyc));
      check("overflow0", ovf0, drop_e[0] <= cyc);
      check("full1", full1, occ(1, cyc) == DEPTH);
      check("busy1", busy1, (occ(1, cyc) > 0) || tx_active(1, cyc));
      check("overflow1", ovf1, drop_e[1] <= cyc);
    end
  end

  // UART line monitor: every cycle of a frame pair must match the expected word.
  task automatic rx_mon(input int which);
    int          cpb;
    exp_t        e;
    bit          have;
    bit          aborted;
    int          errs;
    logic [19:0] frame;
    cpb = cpb_of(which);
    forever begin
      @(negedge clk);
      if (rx_en && rst === 1'b0 && get_tx(which) === 1'b0) begin
        have = 1'b0;
        if (which == 0 && sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
        if (which == 1 && sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
        if (!have) begin
          check($sformatf("rx%0d_unexpected_frame", which), get_tx(which), 1'b1);
          for (int k = 0; k < 100 && get_tx(which) === 1'b0; k++) @(negedge clk);
        end else begin
          check($sformatf("rx%0d_fall_edge", which), cyc, e.fall);
          frame   = {1'b1, e.w[15:8], 1'b0, 1'b1, e.w[7:0], 1'b0};
          errs    = 0;
          aborted = 1'b0;
          for (int k = 0; k < 20 * cpb; k++) begin
            if (k > 0) @(negedge clk);
            if (rst !== 1'b0) begin
              aborted = 1'b1;
              break;
            end
            if (get_tx(which) !== frame[k / cpb]) errs++;
          end
          if (!aborted) check($sformatf("rx%0d_frame_%04h", which, e.w), errs, 0);
        end
      end
    end
  endtask

  initial rx_mon(0);
  initial rx_mon(1);

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    int gap;
    int target;
    rst  = 1'b1;
    din0 = '0;
    din1 = '0;
    v0   = 1'b0;
    v1   = 1'b0;
    @(negedge clk);
    #1;

    // Reset values and a quiet line
    do_reset(2);
    check("rst_tx", tx0, 1'b1);
    check("rst_full", full0, 1'b0);
    check("rst_overflow", ovf0, 1'b0);
    check("rst_busy", busy0, 1'b0);
    check("rst_tx1", tx1, 1'b1);
    chk_en = 1'b1;
    rx_en  = 1'b1;
    edges  = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (tx0 !== 1'b1 || tx1 !== 1'b1) edges++;
    end
    check("idle_line_quiet", edges, 0);

    // Single word: tx falls two edges after the strobe edge
    strobe(0, 16'hA55A);
    check("lat_t0", tx0, 1'b1);
    step(1);
    check("lat_t1", tx0, 1'b1);
    step(1);
    check("lat_t2_fall", tx0, 1'b0);
    wait_idle(0, 200);

    // Ten back-to-back strobes: nine accepted, the tenth dropped
    do_reset(2);
    for (int i = 0; i < 10; i++) strobe(0, 16'(i));
    check("burst_full", full0, 1'b1);
    check("burst_overflow", ovf0, 1'b1);
    wait_idle(0, 9 * 81 + 200);

    // Full FIFO, strobe on the very edge IDLE pops: dropped, count 8 -> 7
    do_reset(2);
    for (int i = 0; i < 9; i++) strobe(0, 16'h0100 + 16'(i));
    target = pop_e[0][1];
    while (cyc + 1 < target) step(1);
    check("pop_edge_full_before", full0, 1'b1);
    check("pop_edge_ovf_before", ovf0, 1'b0);
    strobe(0, 16'hDEAD);
    check("pop_edge_full_after", full0, 1'b0);
    check("pop_edge_ovf_after", ovf0, 1'b1);
    wait_idle(0, 9 * 81 + 200);

    // Reset during the high byte's data bits, then a clean word
    do_reset(2);
    strobe(0, 16'hBEEF);
    step(56);
    rst = 1'b1;
    model_reset();
    step(1);
    rst = 1'b0;
    check("midrst_tx", tx0, 1'b1);
    check("midrst_busy", busy0, 1'b0);
    check("midrst_full", full0, 1'b0);
    check("midrst_ovf", ovf0, 1'b0);
    step(5);
    strobe(0, 16'h1234);
    wait_idle(0, 200);

    // One clock per bit
    strobe(1, 16'hFF00);
    wait_idle(1, 50);

    // Randomised traffic with bursts that overrun the FIFO
    for (int i = 0; i < 40; i++) begin
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 120)) : int'($urandom_range(0, 8));
      step(gap);
      strobe(0, 16'($urandom));
    end
    wait_idle(0, 9 * 81 + 400);
    for (int i = 0; i < 30; i++) begin
      step(int'($urandom_range(0, 24)));
      strobe(1, 16'($urandom));
    end
    wait_idle(1, 9 * 21 + 200);

    check("sb0_drained", sb0.size(), 0);
    check("sb1_drained", sb1.size(), 0);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
